unary2binary: RTL and testbench

- Temporal (rising-edge) decoder that sits directly downstream of the binary-to-unary encoder.
- Samples NUM_CHANNELS unary spike lines against a free-running gamma-cycle tick counter.
- Converts each channel's first rising edge per gamma cycle into a binary arrival time.
- Emits one frame per gamma cycle through a 2-entry valid/ready output buffer, for consumption by downstream binary logic or the scoreboard.

---
 rtl/unary_pkg.sv | 34 +++
 rtl/unary2binary_if.sv | 36 +++
 rtl/u2b_frame_fifo.sv | 107 ++++++++++
 rtl/unary2binary.sv | 168 ++++++++++++++++
 tb/tb_unary2binary.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/unary_pkg.sv
// -----------------------------------------------------------------------------
// unary_pkg
// Shared definitions for the unary (temporal) coding blocks: default sizing
// constants, the decoder FSM state type and the packed frame layout. The
// binary-to-unary encoder bench imports the same package, so both sides agree
// on the frame format.
// No ports (package).
// -----------------------------------------------------------------------------
package unary_pkg;

  // Default sizing shared by the encoder and decoder.
  localparam int DEF_GAMMA_CYCLE_WIDTH = 16;
  localparam int DEF_VALUE_WIDTH       = 8;
  localparam int DEF_NUM_CHANNELS      = 4;

  // Decoder control state.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One decoded frame at default sizing. Channel i occupies caps[i]; the mask
  // sits in the low bits so {caps, mask} matches the flat FIFO word.
  typedef struct packed {
    logic [DEF_NUM_CHANNELS-1:0][DEF_VALUE_WIDTH-1:0] caps;
    logic [DEF_NUM_CHANNELS-1:0]                      mask;
  } frame_t;

  // Width of a flat {caps, mask} frame word for arbitrary sizing.
  function automatic int frame_width(input int num_channels, input int value_width);
    return num_channels * (value_width + 1);
  endfunction

endpackage

// File: rtl/unary2binary_if.sv
// -----------------------------------------------------------------------------
// unary2binary_if
// Valid/ready frame output bus of the unary-to-binary decoder.
//   out_valid      frame available at buffer head (producer -> consumer)
//   out_ready      consumer accepts head frame       (consumer -> producer)
//   binary_output  channel i arrival time in [i*VALUE_WIDTH +: VALUE_WIDTH]
//   spike_mask     bit i set when channel i spiked in the frame
// Modports: master = decoder side, slave = consumer side.
// -----------------------------------------------------------------------------
interface unary2binary_if
  import unary_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int VALUE_WIDTH  = DEF_VALUE_WIDTH
);

  logic                                  out_valid;
  logic                                  out_ready;
  logic [NUM_CHANNELS*VALUE_WIDTH-1:0]   binary_output;
  logic [NUM_CHANNELS-1:0]               spike_mask;

  modport master (
    output out_valid,
    output binary_output,
    output spike_mask,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  binary_output,
    input  spike_mask,
    output out_ready
  );

endinterface

// File: rtl/u2b_frame_fifo.sv
// -----------------------------------------------------------------------------
// u2b_frame_fifo
// Two-entry valid/ready frame buffer with registered head. The head register
// drives the consumer directly, the tail register holds the second frame.
//   clk         clock, posedge
//   rst_n       synchronous active-low reset, empties the buffer
//   push_valid  write push_data this cycle
//   push_data   frame word to store
//   pop_ready   consumer takes the head when head_valid is also set
//   head_valid  buffer not empty
//   head_data   oldest stored frame (zero when empty)
//   drop        one-cycle pulse: push refused because buffer was full
// A push while full is accepted if the head is popped in the same cycle.
// -----------------------------------------------------------------------------
module u2b_frame_fifo #(
  parameter int FRAME_W = 36
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_valid,
  input  logic [FRAME_W-1:0] push_data,
  input  logic               pop_ready,
  output logic               head_valid,
  output logic [FRAME_W-1:0] head_data,
  output logic               drop
);

  localparam logic [FRAME_W-1:0] ZERO_FRAME = {FRAME_W{1'b0}};

  logic [FRAME_W-1:0] head_q, head_d;
  logic [FRAME_W-1:0] tail_q, tail_d;
  logic               head_vld_q, head_vld_d;
  logic               tail_vld_q, tail_vld_d;
  logic               pop_s;
  logic               drop_s;

  // Next-state of the two slots for every push/pop combination.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    drop_s     = 1'b0;
    pop_s      = head_vld_q & pop_ready;

    if (pop_s) begin
      if (push_valid) begin
        // Pop frees a slot first, so the push always lands.
        if (tail_vld_q) begin
          head_d     = tail_q;
          tail_d     = push_data;
          tail_vld_d = 1'b1;
        end else begin
          head_d     = push_data;
          head_vld_d = 1'b1;
          tail_d     = ZERO_FRAME;
          tail_vld_d = 1'b0;
        end
      end else begin
        // Tail advances into the head; an empty tail leaves a cleared head.
        if (tail_vld_q) begin
          head_d     = tail_q;
          head_vld_d = 1'b1;
        end else begin
          head_d     = ZERO_FRAME;
          head_vld_d = 1'b0;
        end
        tail_d     = ZERO_FRAME;
        tail_vld_d = 1'b0;
      end
    end else begin
      if (push_valid) begin
        if (!head_vld_q) begin
          head_d     = push_data;
          head_vld_d = 1'b1;
        end else if (!tail_vld_q) begin
          tail_d     = push_data;
          tail_vld_d = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        drop_s = 1'b0;
      end
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= ZERO_FRAME;
      tail_q     <= ZERO_FRAME;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

  assign head_valid = head_vld_q;
  assign head_data  = head_q;
  assign drop       = drop_s;

endmodule

// File: rtl/unary2binary.sv
// -----------------------------------------------------------------------------
// unary2binary
// Temporal decoder placed after the binary-to-unary encoder. A free-running
// gamma-cycle tick counter frames time; the first rising edge seen on each
// spike line in a frame is captured as that line's binary arrival time. At the
// end of every frame the captures are pushed into a 2-entry output buffer.
//   aclk         clock, posedge
//   grst         synchronous active-low reset
//   run          start/continue gamma cycles (acted on at frame boundaries)
//   unary_input  NUM_CHANNELS spike lines, synchronous to aclk
//   gamma_start  registered pulse during tick 0 of every running frame
//   overflow     sticky: a frame was dropped because the buffer was full
//   out_if       valid/ready frame bus (binary_output, spike_mask)
// -----------------------------------------------------------------------------
module unary2binary
  import unary_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
  parameter int VALUE_WIDTH       = DEF_VALUE_WIDTH,
  parameter int NUM_CHANNELS      = DEF_NUM_CHANNELS
) (
  input  logic                    aclk,
  input  logic                    grst,
  input  logic                    run,
  input  logic [NUM_CHANNELS-1:0] unary_input,
  output logic                    gamma_start,
  output logic                    overflow,
  unary2binary_if.master          out_if
);

  localparam int                     FRAME_W   = frame_width(NUM_CHANNELS, VALUE_WIDTH);
  localparam int                     CAP_W     = NUM_CHANNELS * VALUE_WIDTH;
  localparam logic [VALUE_WIDTH-1:0] LAST_TICK = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [VALUE_WIDTH-1:0] ZERO_TICK = {VALUE_WIDTH{1'b0}};
  localparam logic [VALUE_WIDTH-1:0] ONE_TICK  = VALUE_WIDTH'(1'b1);
  localparam logic [CAP_W-1:0]       ZERO_CAP  = {CAP_W{1'b0}};
  localparam logic [NUM_CHANNELS-1:0] ZERO_CH  = {NUM_CHANNELS{1'b0}};

  state_t                  state_q, state_d;
  logic [VALUE_WIDTH-1:0]  tick_q, tick_d;
  logic [NUM_CHANNELS-1:0] prev_q, prev_d;
  logic [CAP_W-1:0]        cap_q, cap_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                    gamma_start_q, gamma_start_d;
  logic                    overflow_q, overflow_d;

  logic                    frame_end_s;
  logic [NUM_CHANNELS-1:0] rise_s;
  logic [CAP_W-1:0]        cap_upd_s;
  logic [NUM_CHANNELS-1:0] mask_upd_s;
  logic [FRAME_W-1:0]      push_frame_s;
  logic [FRAME_W-1:0]      head_frame_s;
  logic                    head_valid_s;
  logic                    drop_s;

  // Control FSM and tick counter; run only matters in IDLE and on the last tick.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    frame_end_s = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = ZERO_TICK;
        if (run) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (tick_q == LAST_TICK) begin
          frame_end_s = 1'b1;
          tick_d      = ZERO_TICK;
          if (run) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d  = tick_q + ONE_TICK;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = ZERO_TICK;
      end
    endcase
    // Registered so the pulse coincides with the tick-0 cycle it announces.
    gamma_start_d = (state_d == RUN) && (tick_d == ZERO_TICK);
  end

  // First-edge capture per channel; the updated view includes an edge on the last tick.
  always_comb begin
    rise_s     = unary_input & ~prev_q;
    prev_d     = unary_input;
    cap_upd_s  = cap_q;
    mask_upd_s = mask_q;
    if (state_q == RUN) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (rise_s[i] && !mask_q[i]) begin
          cap_upd_s[i*VALUE_WIDTH +: VALUE_WIDTH] = tick_q;
          mask_upd_s[i]                           = 1'b1;
        end else begin
          cap_upd_s[i*VALUE_WIDTH +: VALUE_WIDTH] = cap_q[i*VALUE_WIDTH +: VALUE_WIDTH];
          mask_upd_s[i]                           = mask_q[i];
        end
      end
    end else begin
      cap_upd_s  = cap_q;
      mask_upd_s = mask_q;
    end
  end

  // Frame commit: push the completed captures and clear them for the next frame.
  always_comb begin
    push_frame_s = {cap_upd_s, mask_upd_s};
    if (frame_end_s) begin
      cap_d  = ZERO_CAP;
      mask_d = ZERO_CH;
    end else begin
      cap_d  = cap_upd_s;
      mask_d = mask_upd_s;
    end
    overflow_d = overflow_q | drop_s;
  end

  // Decoder state registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (!grst) begin
      state_q       <= IDLE;
      tick_q        <= ZERO_TICK;
      prev_q        <= ZERO_CH;
      cap_q         <= ZERO_CAP;
      mask_q        <= ZERO_CH;
      gamma_start_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      prev_q        <= prev_d;
      cap_q         <= cap_d;
      mask_q        <= mask_d;
      gamma_start_q <= gamma_start_d;
      overflow_q    <= overflow_d;
    end
  end

  u2b_frame_fifo #(
    .FRAME_W (FRAME_W)
  ) u_fifo (
    .clk        (aclk),
    .rst_n      (grst),
    .push_valid (frame_end_s),
    .push_data  (push_frame_s),
    .pop_ready  (out_if.out_ready),
    .head_valid (head_valid_s),
    .head_data  (head_frame_s),
    .drop       (drop_s)
  );

  assign out_if.out_valid     = head_valid_s;
  assign out_if.binary_output = head_frame_s[FRAME_W-1:NUM_CHANNELS];
  assign out_if.spike_mask    = head_frame_s[NUM_CHANNELS-1:0];
  assign gamma_start          = gamma_start_q;
  assign overflow             = overflow_q;

endmodule

// File: tb/tb_unary2binary.sv
// -----------------------------------------------------------------------------
// tb_unary2binary
// Directed bench for the unary-to-binary decoder. Each frame's spike pattern
// is laid out tick by tick; the frame the decoder should emit is queued when
// the frame is played, and a monitor compares every accepted output frame
// against the queue head. Direct checks cover reset, gamma_start, latency,
// overflow and the buffer-full corner cases.
// -----------------------------------------------------------------------------
module tb_unary2binary;
  import unary_pkg::*;

  localparam int G  = DEF_GAMMA_CYCLE_WIDTH;
  localparam int VW = DEF_VALUE_WIDTH;
  localparam int NC = DEF_NUM_CHANNELS;

  logic          aclk = 1'b0;
  logic          grst;
  logic          run;
  logic [NC-1:0] unary_input;
  logic          gamma_start;
  logic          overflow;

  int            checks = 0;
  int            errors = 0;
  frame_t        exp_q[$];
  logic [NC-1:0] pat[G];

  unary2binary_if #(.NUM_CHANNELS(NC), .VALUE_WIDTH(VW)) u_if ();

  unary2binary #(
    .GAMMA_CYCLE_WIDTH (G),
    .VALUE_WIDTH       (VW),
    .NUM_CHANNELS      (NC)
  ) dut (
    .aclk        (aclk),
    .grst        (grst),
    .run         (run),
    .unary_input (unary_input),
    .gamma_start (gamma_start),
    .overflow    (overflow),
    .out_if      (u_if)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input int c0, input int c1, input int c2, input int c3,
                                input logic [NC-1:0] m);
    frame_t f;
    f         = '0;
    f.caps[0] = VW'(c0);
    f.caps[1] = VW'(c1);
    f.caps[2] = VW'(c2);
    f.caps[3] = VW'(c3);
    f.mask    = m;
    return f;
  endfunction

  task automatic clear_pat();
    for (int k = 0; k < G; k++) pat[k] = '0;
  endtask

  task automatic set_hi(input int ch, input int from, input int upto);
    for (int k = from; k <= upto; k++) pat[k][ch] = 1'b1;
  endtask

  // Called #1 after the posedge that starts tick 0; returns #1 after the commit edge.
  task automatic play_frame(input logic last_run, input logic rdy1, input logic rdy15);
    for (int k = 0; k < G; k++) begin
      unary_input = pat[k];
      if (k == 1) begin
        u_if.out_ready = rdy1;
        chk("gamma_start_low_mid_frame", gamma_start, 1'b0);
      end
      if (k == G - 1) begin
        run            = last_run;
        u_if.out_ready = rdy15;
      end
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic start_run();
    run = 1'b1;
    @(posedge aclk);
    #1;
    chk("gamma_start_on_first_tick", gamma_start, 1'b1);
  endtask

  // Scoreboard monitor: every accepted frame must match the oldest queued frame.
  always @(negedge aclk) begin
    frame_t e;
    if (grst && u_if.out_valid && u_if.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got data %0h mask %0h with nothing expected",
                 u_if.binary_output, u_if.spike_mask);
      end else begin
        e = exp_q.pop_front();
        if (u_if.binary_output !== e.caps || u_if.spike_mask !== e.mask) begin
          errors++;
          $display("FAIL frame_compare: got data %0h mask %0h expected data %0h mask %0h",
                   u_if.binary_output, u_if.spike_mask, e.caps, e.mask);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    grst           = 1'b0;
    run            = 1'b0;
    unary_input    = '0;
    u_if.out_ready = 1'b1;
    clear_pat();
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_out_valid", u_if.out_valid, 1'b0);
    chk("reset_binary_output", u_if.binary_output, 32'h0);
    chk("reset_spike_mask", u_if.spike_mask, 4'h0);
    chk("reset_gamma_start", gamma_start, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    grst = 1'b1;
    @(posedge aclk);
    #1;
    chk("idle_gamma_start", gamma_start, 1'b0);

    // 1: ch0 rises at tick 1, ch2 at tick 8.
    start_run();
    chk("empty_before_first_frame", u_if.out_valid, 1'b0);
    clear_pat(); set_hi(0, 1, 2); set_hi(2, 8, 9);
    exp_q.push_back(mk(1, 0, 8, 0, 4'b0101));
    play_frame(1'b1, 1'b1, 1'b1);
    chk("valid_one_cycle_after_last_tick", u_if.out_valid, 1'b1);
    chk("gamma_start_after_wrap", gamma_start, 1'b1);

    // 2: encoder-style thermometer lines for values 1 and 8.
    clear_pat(); set_hi(0, 1, G - 1); set_hi(1, 8, G - 1);
    exp_q.push_back(mk(1, 8, 0, 0, 4'b0011));
    play_frame(1'b1, 1'b1, 1'b1);

    // 3: ch1 high across the boundary, ch3 pulses twice, ch2 rises on the last tick.
    clear_pat(); set_hi(1, 0, 5); set_hi(3, 3, 4); set_hi(3, 10, 11); set_hi(2, G - 1, G - 1);
    exp_q.push_back(mk(0, 0, 15, 3, 4'b1100));
    play_frame(1'b1, 1'b1, 1'b1);

    // 4: consumer stalls for three frames; the third is dropped.
    clear_pat(); set_hi(0, 2, 3);
    exp_q.push_back(mk(2, 0, 0, 0, 4'b0001));
    play_frame(1'b1, 1'b0, 1'b0);
    clear_pat(); set_hi(1, 5, 6);
    exp_q.push_back(mk(0, 5, 0, 0, 4'b0010));
    play_frame(1'b1, 1'b0, 1'b0);
    chk("no_overflow_with_two_buffered", overflow, 1'b0);
    clear_pat(); set_hi(3, 7, 8);
    play_frame(1'b0, 1'b0, 1'b0);
    chk("overflow_after_drop", overflow, 1'b1);
    chk("valid_while_stalled", u_if.out_valid, 1'b1);
    chk("head_data_held", u_if.binary_output, 32'h0000_0002);
    chk("head_mask_held", u_if.spike_mask, 4'b0001);
    chk("gamma_start_idle_after_stop", gamma_start, 1'b0);
    u_if.out_ready = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    chk("drained_after_stall", u_if.out_valid, 1'b0);
    chk("overflow_sticky", overflow, 1'b1);
    chk("scoreboard_empty_after_stall", exp_q.size(), 0);

    // 5: buffer full, consumer ready exactly on the commit cycle.
    grst = 1'b0;
    @(posedge aclk);
    #1;
    grst = 1'b1;
    chk("overflow_cleared_by_reset", overflow, 1'b0);
    start_run();
    clear_pat(); set_hi(0, 4, 5);
    exp_q.push_back(mk(4, 0, 0, 0, 4'b0001));
    play_frame(1'b1, 1'b0, 1'b0);
    clear_pat(); set_hi(1, 6, 7);
    exp_q.push_back(mk(0, 6, 0, 0, 4'b0010));
    play_frame(1'b1, 1'b0, 1'b0);
    clear_pat(); set_hi(2, 9, 10);
    exp_q.push_back(mk(0, 0, 9, 0, 4'b0100));
    play_frame(1'b0, 1'b0, 1'b1);
    chk("no_overflow_push_pop_full", overflow, 1'b0);
    chk("valid_after_push_pop_full", u_if.out_valid, 1'b1);
    repeat (4) @(posedge aclk);
    #1;
    chk("drained_after_push_pop", u_if.out_valid, 1'b0);
    chk("scoreboard_empty_after_push_pop", exp_q.size(), 0);

    // 6: reset at tick 7 with one frame buffered and a partial capture pending.
    start_run();
    clear_pat(); set_hi(0, 3, 4);
    play_frame(1'b1, 1'b0, 1'b0);
    chk("frame_buffered_before_reset", u_if.out_valid, 1'b1);
    clear_pat(); set_hi(1, 2, 3);
    for (int k = 0; k < 7; k++) begin
      unary_input = pat[k];
      @(posedge aclk);
      #1;
    end
    grst        = 1'b0;
    run         = 1'b0;
    unary_input = '0;
    @(posedge aclk);
    #1;
    chk("midframe_reset_out_valid", u_if.out_valid, 1'b0);
    chk("midframe_reset_mask", u_if.spike_mask, 4'h0);
    chk("midframe_reset_data", u_if.binary_output, 32'h0);
    chk("midframe_reset_gamma_start", gamma_start, 1'b0);
    grst = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("idle_after_reset_gamma_start", gamma_start, 1'b0);
    chk("idle_after_reset_valid", u_if.out_valid, 1'b0);
    u_if.out_ready = 1'b1;
    start_run();
    clear_pat(); set_hi(3, 11, 12);
    exp_q.push_back(mk(0, 0, 0, 11, 4'b1000));
    play_frame(1'b0, 1'b1, 1'b1);
    chk("valid_after_rerun", u_if.out_valid, 1'b1);
    repeat (3) @(posedge aclk);
    #1;
    chk("final_drained", u_if.out_valid, 1'b0);
    chk("scoreboard_empty_at_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
